// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide engine: shift-add multiply, restoring divide,
// one iteration per clock, single-cycle data_resultRDY pulse on completion.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_mul_q, is_mul_d;
  logic               sign_q, sign_d;
  logic               div_zero_q, div_zero_d;
  logic               div_ovf_q, div_ovf_d;
  // Multiply: mcand shifts left, mplr shifts right. Divide: mcand[W-1:0] is the
  // dividend/quotient shift register, mplr is the divisor, acc[W:0] the remainder.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [2*WIDTH-1:0] mul_sum, mul_final;
  logic [WIDTH:0]     div_shift, div_diff, rem_next;
  logic [WIDTH-1:0]   quo_next, quo_final;
  logic               quo_bit, mul_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    mul_sum   = acc_q + (mplr_q[0] ? mcand_q : '0);
    mul_final = sign_q ? -mul_sum : mul_sum;
    // Product fits in WIDTH bits only if the upper bits all match bit WIDTH-1.
    mul_ovf   = ~((&mul_final[2*WIDTH-1:WIDTH-1]) | ~(|mul_final[2*WIDTH-1:WIDTH-1]));

    div_shift = {acc_q[WIDTH-1:0], mcand_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mplr_q};
    quo_bit   = ~div_diff[WIDTH];
    rem_next  = quo_bit ? div_diff : div_shift;
    quo_next  = {mcand_q[WIDTH-2:0], quo_bit};
    quo_final = sign_q ? -quo_next : quo_next;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_mul_d   = is_mul_q;
    sign_d     = sign_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;
    acc_d      = acc_q;
    result_d   = result_q;
    exc_d      = exc_q;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        count_d = count_q + CW'(1);
        if (is_mul_q) begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
        end else begin
          acc_d   = {{(WIDTH-1){1'b0}}, rem_next};
          mcand_d = {{WIDTH{1'b0}}, quo_next};
        end
        if (count_q == LastCount) begin
          state_d = StDone;
          if (is_mul_q) begin
            result_d = mul_final[WIDTH-1:0];
            exc_d    = mul_ovf;
          end else if (div_zero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo_final;
            exc_d    = div_ovf_q;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start in any state (re)loads the operands; an op in flight is dropped.
    if (ctrl_MULT || ctrl_DIV) begin
      state_d    = StBusy;
      count_d    = '0;
      is_mul_d   = ctrl_MULT;
      sign_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero_d = (data_operandB == '0);
      div_ovf_d  = (data_operandA == MinVal) && (data_operandB == '1);
      mcand_d    = {{WIDTH{1'b0}}, mag(data_operandA)};
      mplr_d     = mag(data_operandB);
      acc_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      is_mul_q   <= 1'b0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_mul_q   <= is_mul_d;
      sign_q     <= sign_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      mcand_q    <= mcand_d;
      mplr_q     <= mplr_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table plus restart and reset sequences.
// Cycle k is sampled on the falling edge just before rising edge k; edge 0 starts.
module tb_multdiv_unit;

  logic        clock, reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] op_a, op_b, data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        mul;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[$];

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          rdy_cycle = 0;
    int          rdy_cnt   = 0;
    logic        busy_ok   = 1'b1;
    logic [31:0] got_r     = '0;
    logic        got_e     = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clock);
      if (k > 0) begin
        if (data_resultRDY) begin
          rdy_cnt++;
          rdy_cycle = k;
          got_r = data_result;
          got_e = data_exception;
        end
        if (busy !== (k <= 33)) busy_ok = 1'b0;
      end
      if (k == 0) begin
        ctrl_MULT = v.mul;
        ctrl_DIV  = v.div;
        op_a      = v.a;
        op_b      = v.b;
      end else begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
      end
    end
    check($sformatf("vec%0d rdy_cycle", idx), 64'(rdy_cycle), 64'd33);
    check($sformatf("vec%0d rdy_count", idx), 64'(rdy_cnt), 64'd1);
    check($sformatf("vec%0d result", idx), 64'(got_r), 64'(v.res));
    check($sformatf("vec%0d exception", idx), 64'(got_e), 64'(v.exc));
    check($sformatf("vec%0d busy_window", idx), 64'(busy_ok), 64'd1);
    check($sformatf("vec%0d result_hold", idx), 64'(data_result), 64'(v.res));
  endtask

  initial begin
    int   rdy_cnt, rdy_cycle;
    logic [31:0] got_r;
    logic quiet_ok;

    vecs.push_back('{1'b1, 1'b0, 32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFEF,   32'd5,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd100,        32'd0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'd3,          32'd4,        32'd12,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'd0,          32'hFFFFFFFB, 32'd0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000,   32'd1,        32'h80000000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd0,          32'd5,        32'd0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd5,          32'd7,        32'd0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 1'b0});

    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Restart: mult 9x9 at edge 0, div 20/4 at edge 10; only the divide completes.
    rdy_cnt = 0; rdy_cycle = 0; got_r = '0;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clock);
      if (k > 0 && data_resultRDY) begin
        rdy_cnt++;
        rdy_cycle = k;
        got_r = data_result;
      end
      ctrl_MULT = (k == 0);
      ctrl_DIV  = (k == 10);
      op_a      = (k == 0) ? 32'd9 : (k == 10) ? 32'd20 : $urandom;
      op_b      = (k == 0) ? 32'd9 : (k == 10) ? 32'd4  : $urandom;
    end
    check("restart rdy_count", 64'(rdy_cnt), 64'd1);
    check("restart rdy_cycle", 64'(rdy_cycle), 64'd43);
    check("restart result", 64'(got_r), 64'd5);

    // Reset in cycle 15 of a divide: outputs clear at once, no late RDY.
    for (int k = 0; k <= 15; k++) begin
      @(negedge clock);
      ctrl_DIV = (k == 0);
      op_a     = 32'd100;
      op_b     = 32'd7;
    end
    reset = 1'b0;
    #1;
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset exception", 64'(data_exception), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    quiet_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("postreset quiet", 64'(quiet_ok), 64'd1);
    run_vec('{1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0}, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
